// File: rtl/dmi_pkg.sv
// Shared DMI definitions: status encoding, return-path FSM states and default widths.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  // BUSY is never produced by the core side; the TCK side maps overrun onto it.
  typedef enum logic [1:0] {
    DMI_SUCCESS = 2'd0,
    DMI_FAILED  = 2'd2,
    DMI_BUSY    = 2'd3
  } dmi_status_e;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_REQ  = 2'd1,
    RSP_WAIT = 2'd2
  } dmi_rsp_state_e;

endpackage

// File: rtl/dmi_core_to_jtag_rsp.sv
// Core-side DMI return path: turns a synchronized access pulse into one valid/ready
// request, waits for the response (with timeout) and holds the result for TCK sampling.
module dmi_core_to_jtag_rsp
  import dmi_pkg::*;
#(
  parameter int ADDR_W         = DMI_ADDR_W,
  parameter int DATA_W         = DMI_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_en,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              dmi_req_valid,
  output logic              dmi_req_wr,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [DATA_W-1:0] dmi_req_wdata,
  input  logic              dmi_req_ready,
  input  logic              dmi_rsp_valid,
  input  logic [DATA_W-1:0] dmi_rsp_rdata,
  input  logic              dmi_rsp_err,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic              done_tgl,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmi_rsp_state_e    state;
  logic [CNT_W-1:0]  cnt;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_take;
  logic              tmo_hit;

  // A response coinciding with the accept counts as already being in WAIT_RSP.
  assign rsp_take = dmi_rsp_valid &&
                    ((state == RSP_WAIT) || (state == RSP_REQ && dmi_req_ready));
  assign tmo_hit  = (state != RSP_IDLE) && (cnt == CNT_LAST) && !rsp_take;

  assign dmi_req_valid = (state == RSP_REQ);
  assign dmi_req_wr    = req_wr;
  assign dmi_req_addr  = req_addr;
  assign dmi_req_wdata = req_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RSP_IDLE;
      cnt        <= '0;
      req_wr     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      rd_data    <= '0;
      rsp_status <= DMI_SUCCESS;
      busy       <= 1'b0;
      done_tgl   <= 1'b0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (reg_en) begin
            req_wr    <= reg_wr_en;
            req_addr  <= reg_addr;
            req_wdata <= reg_wdata;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= RSP_REQ;
          end
        end
        RSP_REQ, RSP_WAIT: begin
          if (rsp_take) begin
            if (!req_wr) begin
              rd_data <= dmi_rsp_rdata;
            end
            rsp_status <= dmi_rsp_err ? DMI_FAILED : DMI_SUCCESS;
            busy       <= 1'b0;
            done_tgl   <= ~done_tgl;
            state      <= RSP_IDLE;
          end else if (tmo_hit) begin
            rsp_status <= DMI_FAILED;
            busy       <= 1'b0;
            done_tgl   <= ~done_tgl;
            state      <= RSP_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == RSP_REQ && dmi_req_ready) begin
              state <= RSP_WAIT;
            end
          end
        end
        default: state <= RSP_IDLE;
      endcase
    end
  end

  // Set wins over a coincident clear so a dropped access is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (reg_en && state != RSP_IDLE) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmi_core_to_jtag_rsp.sv
// Scoreboard bench for dmi_core_to_jtag_rsp: stimulus pushes expected requests and
// completions; monitors pop and compare when the DUT accepts a request or flips done_tgl.
module tb_dmi_core_to_jtag_rsp;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_en, reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          dmi_req_valid, dmi_req_wr;
  logic [AW-1:0] dmi_req_addr;
  logic [DW-1:0] dmi_req_wdata;
  logic          dmi_req_ready;
  logic          dmi_rsp_valid;
  logic [DW-1:0] dmi_rsp_rdata;
  logic          dmi_rsp_err;
  logic [DW-1:0] rd_data;
  logic [1:0]    rsp_status;
  logic          busy, done_tgl, overrun, clr_overrun;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic [DW-1:0] rd;
    logic [1:0]    st;
  } cmp_t;

  req_t exp_req[$];
  cmp_t exp_cmp[$];

  int checks = 0;
  int errors = 0;
  int busy_run = 0;
  int last_busy_len = 0;
  logic prev_tgl = 1'b0;

  dmi_core_to_jtag_rsp #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .dmi_req_valid(dmi_req_valid), .dmi_req_wr(dmi_req_wr),
    .dmi_req_addr(dmi_req_addr), .dmi_req_wdata(dmi_req_wdata),
    .dmi_req_ready(dmi_req_ready),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_rdata(dmi_rsp_rdata), .dmi_rsp_err(dmi_rsp_err),
    .rd_data(rd_data), .rsp_status(rsp_status), .busy(busy), .done_tgl(done_tgl),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // Request monitor: an accept happens on the next edge when valid & ready are both high.
  always @(negedge clk) begin
    if (rst_n && dmi_req_valid && dmi_req_ready) begin
      if (exp_req.size() == 0) begin
        check("unexpected_request", 64'(dmi_req_addr), 64'h1_0000);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        check("req_wr", 64'(dmi_req_wr), 64'(r.wr));
        check("req_addr", 64'(dmi_req_addr), 64'(r.addr));
        check("req_wdata", 64'(dmi_req_wdata), 64'(r.wd));
      end
    end
  end

  // Completion monitor: each done_tgl flip must match the next queued result.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tgl = done_tgl;
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
      end else begin
        if (busy_run != 0) last_busy_len = busy_run;
        busy_run = 0;
      end
      if (done_tgl != prev_tgl) begin
        prev_tgl = done_tgl;
        if (exp_cmp.size() == 0) begin
          check("unexpected_completion", 64'(rd_data), 64'h1_0000_0000);
        end else begin
          cmp_t c;
          c = exp_cmp.pop_front();
          check("cmp_rd_data", 64'(rd_data), 64'(c.rd));
          check("cmp_status", 64'(rsp_status), 64'(c.st));
          check("cmp_busy_low", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    reg_en = 1'b1; reg_wr_en = wr; reg_addr = a; reg_wdata = wd;
    @(posedge clk); #1;
    reg_en = 1'b0; reg_wr_en = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] rd, input logic err);
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = rd; dmi_rsp_err = err;
    @(posedge clk); #1;
    dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    if (!seen) check(name, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, 64'(dmi_req_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done_tgl"}, 64'(done_tgl), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    check({tag, "_status"}, 64'(rsp_status), 64'd0);
    check({tag, "_req_addr"}, 64'(dmi_req_addr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; reg_en = 0; reg_wr_en = 0; reg_addr = '0; reg_wdata = '0;
    dmi_req_ready = 0; dmi_rsp_valid = 0; dmi_rsp_rdata = '0; dmi_rsp_err = 0;
    clr_overrun = 0;
    cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Read 0x11, DM ready at once, response after three WAIT cycles.
    dmi_req_ready = 1'b1;
    exp_req.push_back('{1'b0, 7'h11, 32'h0});
    exp_cmp.push_back('{32'hDEADBEEF, 2'd0});
    issue(1'b0, 7'h11, 32'h0);
    check("t1_req_valid_next", 64'(dmi_req_valid), 64'd1);
    check("t1_busy_next", 64'(busy), 64'd1);
    cyc(4);
    respond(32'hDEADBEEF, 1'b0);

    // Back-to-back write with error; garbage rdata must not reach rd_data.
    exp_req.push_back('{1'b1, 7'h10, 32'h1});
    exp_cmp.push_back('{32'hDEADBEEF, 2'd2});
    issue(1'b1, 7'h10, 32'h1);
    check("t1_busy_len", 64'(last_busy_len), 64'd5);
    cyc(2);
    respond(32'hFFFFFFFF, 1'b1);
    cyc(2);

    // Timeout with DM never ready.
    dmi_req_ready = 1'b0;
    exp_cmp.push_back('{32'hDEADBEEF, 2'd2});
    issue(1'b0, 7'h05, 32'h0);
    wait_not_busy(20, "tmo_wait_busy");
    @(posedge clk); #1;
    check("tmo_busy_len", 64'(last_busy_len), 64'(TMO));
    check("tmo_req_valid_drop", 64'(dmi_req_valid), 64'd0);
    cyc(1);

    // Overrun: second pulse during WAIT_RSP, then clear.
    dmi_req_ready = 1'b1;
    exp_req.push_back('{1'b0, 7'h22, 32'h0});
    exp_cmp.push_back('{32'h12345678, 2'd0});
    issue(1'b0, 7'h22, 32'h0);
    cyc(1);
    issue(1'b1, 7'h7F, 32'hAAAA);
    check("ovr_set", 64'(overrun), 64'd1);
    respond(32'h12345678, 1'b0);
    cyc(1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    check("ovr_clear", 64'(overrun), 64'd0);

    // Set and clear in the same cycle: set wins.
    exp_req.push_back('{1'b0, 7'h23, 32'h0});
    exp_cmp.push_back('{32'h0000ABCD, 2'd0});
    issue(1'b0, 7'h23, 32'h0);
    cyc(1);
    clr_overrun = 1'b1;
    issue(1'b0, 7'h24, 32'h0);
    clr_overrun = 1'b0;
    check("ovr_set_wins", 64'(overrun), 64'd1);
    respond(32'h0000ABCD, 1'b0);
    cyc(1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    check("ovr_clear2", 64'(overrun), 64'd0);

    // Asynchronous reset while waiting for a response.
    exp_req.push_back('{1'b0, 7'h30, 32'h0});
    issue(1'b0, 7'h30, 32'h0);
    cyc(1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    respond(32'h55555555, 1'b0);
    cyc(2);
    check("late_rsp_rd_data", 64'(rd_data), 64'd0);
    check("late_rsp_done_tgl", 64'(done_tgl), 64'd0);
    check("late_rsp_busy", 64'(busy), 64'd0);

    // Response lands in the timeout-expiry cycle and wins.
    exp_req.push_back('{1'b0, 7'h3F, 32'h0});
    exp_cmp.push_back('{32'hCAFEF00D, 2'd0});
    issue(1'b0, 7'h3F, 32'h0);
    cyc(TMO - 1);
    respond(32'hCAFEF00D, 1'b0);
    cyc(2);
    check("expiry_busy_len", 64'(last_busy_len), 64'(TMO));

    cyc(3);
    check("pending_completions", 64'(exp_cmp.size()), 64'd0);
    check("pending_requests", 64'(exp_req.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_core_to_jtag_rsp.md
# dmi_core_to_jtag_rsp

Core-clock side of the DMI return path. It takes the single-cycle `reg_en`/`reg_wr_en` pulses produced by the JTAG-to-core synchronizer and issues one valid/ready request to the debug module. It then waits for the response, with a timeout. Finally it presents the read data, the status, a `busy` level and a completion toggle, all held stable so the TCK domain can sample them through its own 2-flop synchronizers.

## Interface
Parameters:
- `ADDR_W`, 7, DMI address width
- `DATA_W`, 32, DMI data width
- `TIMEOUT_CYCLES`, 1024, core cycles from request issue to forced failure; legal range 2..65535

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  core reset, asynchronous, active-low
- `reg_en`  in  1  one-cycle access pulse from the JTAG-to-core synchronizer
- `reg_wr_en`  in  1  one-cycle write qualifier, valid with `reg_en`
- `reg_addr`  in  ADDR_W  address; held stable by JTAG while a pulse can occur
- `reg_wdata`  in  DATA_W  write data; held stable like `reg_addr`
- `dmi_req_valid`  out  1  request valid to the debug module
- `dmi_req_wr`  out  1  1 = write, 0 = read
- `dmi_req_addr`  out  ADDR_W  request address
- `dmi_req_wdata`  out  DATA_W  request write data
- `dmi_req_ready`  in  1  debug module accepts the request
- `dmi_rsp_valid`  in  1  response valid, one cycle
- `dmi_rsp_rdata`  in  DATA_W  response read data
- `dmi_rsp_err`  in  1  response error
- `rd_data`  out  DATA_W  last read data, held between accesses
- `rsp_status`  out  2  0 = success, 2 = failed (error or timeout)
- `busy`  out  1  access in flight
- `done_tgl`  out  1  toggles once per completed or timed-out access
- `overrun`  out  1  sticky: an access arrived while `busy`
- `clr_overrun`  in  1  one-cycle clear (dmireset), already synchronized

## Operation
- States: IDLE, REQ, WAIT_RSP.
- IDLE, with `reg_en`=1:
  - capture `reg_wr_en`, `reg_addr` and `reg_wdata` into request registers;
  - set `busy`;
  - clear the timeout counter;
  - go to REQ.
- REQ:
  - `dmi_req_valid`=1, driven from registers only;
  - on `dmi_req_valid & dmi_req_ready`, go to WAIT_RSP;
  - if `dmi_rsp_valid` arrives in the same cycle as the accept, treat it as a response in WAIT_RSP.
- WAIT_RSP, with `dmi_rsp_valid`=1:
  - reads only: `rd_data` <= `dmi_rsp_rdata`; writes leave `rd_data` unchanged;
  - `rsp_status` <= `dmi_rsp_err` ? 2 : 0;
  - clear `busy`, flip `done_tgl`, return to IDLE.
- Timeout:
  - the counter runs in REQ and WAIT_RSP;
  - on reaching `TIMEOUT_CYCLES-1` with no response: `rsp_status`=2, `rd_data` unchanged, `dmi_req_valid` dropped, `busy` cleared, `done_tgl` flipped, return to IDLE;
  - a response arriving in the expiry cycle wins over the timeout.
- `reg_en` while not IDLE: the access is dropped and `overrun` <= 1.
- `clr_overrun` clears `overrun`; if a set occurs in the same cycle, the set wins.
- `dmi_rsp_valid` in IDLE or REQ (other than the same-cycle case above) is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- `reg_en` in cycle N gives `dmi_req_valid`=1 and `busy`=1 in cycle N+1.
- Response in cycle M updates `rd_data`, `rsp_status` and `done_tgl`, and drops `busy`, in cycle M+1. All of these change in the same edge.
- `rd_data` and `rsp_status` never change while `busy`=0. They are therefore stable for at least 2 TCK edges after the `done_tgl` flip, for synchronizer sampling.
- Back-to-back: a new `reg_en` is accepted in the first IDLE cycle after completion.
- Asynchronous reset mid-access: everything returns to reset values immediately. No response is reported and `done_tgl` does not flip.

## Structure
- Shared package `dmi_pkg` holds:
  - the `dmi_status_e` encoding (SUCCESS=2'd0, FAILED=2'd2, BUSY=2'd3 reserved for the TCK side's overrun mapping);
  - the `dmi_rsp_state_e` state enum;
  - the default width constants.
- Single module. The timeout counter is inline, `$clog2(TIMEOUT_CYCLES)` bits wide. No sub-module.

## Test plan
- Read, addr 0x11, DM ready immediately, response 3 cycles later with rdata 0xDEADBEEF, err 0 -> `rd_data`=0xDEADBEEF, `rsp_status`=0, `done_tgl` flips once, `busy` high for 5 cycles.
- Write, addr 0x10, wdata 0x1, err 1 -> `dmi_req_wr`=1 with wdata 0x1; `rsp_status`=2; `rd_data` keeps its prior value.
- `dmi_req_ready` held low, `TIMEOUT_CYCLES`=8 -> `busy` drops 8 cycles after issue, `rsp_status`=2, `dmi_req_valid` drops, one toggle.
- Second `reg_en` during WAIT_RSP -> no second request issued, `overrun`=1; `clr_overrun` pulse -> 0; set and clear in the same cycle -> stays 1.
- `rst_n` asserted in WAIT_RSP -> all outputs 0 asynchronously; a late `dmi_rsp_valid` after reset release is ignored.
- Response in the exact timeout-expiry cycle -> response data and status are reported, not the timeout failure.
